register_file_mp: RTL and testbench

Parametrised multi-read-port register file. It is the next-generation storage for the datapath: configurable width and depth, N independent registered read ports, one write port and a selectable read-during-write policy. It keeps the dedicated register-0 tap that the control logic consumes. Unlike the previous file, every entry clears on reset and read-port validity is explicit.

---
 rtl/register_file_mp.sv | 70 +++++++
 tb/tb_register_file_mp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-read-port flop register file: one write port, NUM_RD registered read
// ports with per-port valid, selectable read-during-write policy and an entry-0 tap.
module register_file_mp #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int NUM_RD      = 2,
  parameter int WRITE_FIRST = 1,
  parameter int ZERO_RO     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [DATA_W-1:0]        reg_zero
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  // Entry 0 is never written when it is hardwired to zero.
  assign wr_ok = write_en && !((ZERO_RO != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign reg_zero = (ZERO_RO != 0) ? '0 : mem[0];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_p0;
    logic              byp_p0;
    logic [DATA_W-1:0] word_p0;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;

    assign addr_p0 = rd_addr[i*ADDR_W +: ADDR_W];
    assign byp_p0  = (WRITE_FIRST != 0) && wr_ok && (wr_addr == addr_p0);
    assign word_p0 = byp_p0 ? wr_data : mem[addr_p0];

    // p0 -> p1: registered read data and its valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_p1 <= '0;
        vld_p1  <= 1'b0;
      end else begin
        vld_p1 <= rd_en[i];
        if (rd_en[i]) begin
          data_p1 <= word_p0;
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data_p1;
    assign rd_valid[i]                 = vld_p1;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: three configurations driven from one clock,
// checked every cycle against array-based reference models.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        write_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;
  logic [7:0]  reg_zero_a, reg_zero_b;

  logic        c_write_en;
  logic [2:0]  c_wr_addr;
  logic [15:0] c_wr_data;
  logic [2:0]  c_rd_en;
  logic [8:0]  c_rd_addr;
  logic [47:0] c_rd_data;
  logic [2:0]  c_rd_valid;
  logic [15:0] c_reg_zero;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ma [32];
  logic [7:0]  mb [32];
  logic [15:0] mc [8];
  logic [7:0]  ea_d [2];
  logic [7:0]  eb_d [2];
  logic [1:0]  e_v;
  logic [15:0] ec_d [3];
  logic [2:0]  ec_v;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(8), .ADDR_W(5), .NUM_RD(2), .WRITE_FIRST(1), .ZERO_RO(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .reg_zero(reg_zero_a));

  register_file_mp #(.DATA_W(8), .ADDR_W(5), .NUM_RD(2), .WRITE_FIRST(0), .ZERO_RO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .reg_zero(reg_zero_b));

  register_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .WRITE_FIRST(1), .ZERO_RO(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .write_en(c_write_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid),
    .reg_zero(c_reg_zero));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    write_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
    c_write_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_rd_en = '0; c_rd_addr = '0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin ma[k] = '0; mb[k] = '0; end
    for (int k = 0; k < 8; k++) mc[k] = '0;
    for (int p = 0; p < 2; p++) begin ea_d[p] = '0; eb_d[p] = '0; end
    for (int p = 0; p < 3; p++) ec_d[p] = '0;
    e_v = '0; ec_v = '0;
  endtask

  task automatic check_all(input string tag);
    for (int p = 0; p < 2; p++) begin
      chk({tag, "_a_data"}, 64'(rd_data_a[p*8 +: 8]), 64'(ea_d[p]));
      chk({tag, "_a_valid"}, 64'(rd_valid_a[p]), 64'(e_v[p]));
      chk({tag, "_b_data"}, 64'(rd_data_b[p*8 +: 8]), 64'(eb_d[p]));
      chk({tag, "_b_valid"}, 64'(rd_valid_b[p]), 64'(e_v[p]));
    end
    chk({tag, "_a_zero"}, 64'(reg_zero_a), 64'(ma[0]));
    chk({tag, "_b_zero"}, 64'(reg_zero_b), 64'(mb[0]));
    for (int p = 0; p < 3; p++) begin
      chk({tag, "_c_data"}, 64'(c_rd_data[p*16 +: 16]), 64'(ec_d[p]));
      chk({tag, "_c_valid"}, 64'(c_rd_valid[p]), 64'(ec_v[p]));
    end
    chk({tag, "_c_zero"}, 64'(c_reg_zero), 64'(mc[0]));
  endtask

  // Predict the outcome of the coming edge from the current inputs, then clock and compare.
  task automatic cycle(input string tag);
    logic [4:0] a;
    logic [2:0] ca;
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) begin
        a = rd_addr[p*5 +: 5];
        ea_d[p] = (write_en && wr_addr == a) ? wr_data : ma[a];
        eb_d[p] = mb[a];
      end
    end
    e_v = rd_en;
    for (int p = 0; p < 3; p++) begin
      if (c_rd_en[p]) begin
        ca = c_rd_addr[p*3 +: 3];
        ec_d[p] = (c_write_en && c_wr_addr == ca) ? c_wr_data : mc[ca];
      end
    end
    ec_v = c_rd_en;
    if (write_en) begin
      ma[wr_addr] = wr_data;
      if (wr_addr != 5'd0) mb[wr_addr] = wr_data;
    end
    if (c_write_en) mc[c_wr_addr] = c_wr_data;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    idle();
    model_clear();
    #1 rst_n = 1'b0;
    #1 check_all("reset0");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill every address with 0xA5 while reading randomly.
    for (int k = 0; k < 32; k++) begin
      write_en = 1'b1; wr_addr = 5'(k); wr_data = 8'hA5;
      rd_en = 2'b11; rd_addr = 10'($urandom);
      c_write_en = 1'b1; c_wr_addr = 3'(k); c_wr_data = 16'hA5A5;
      c_rd_en = 3'b111; c_rd_addr = 9'($urandom);
      cycle("fill");
    end
    idle();
    #3 rst_n = 1'b0;
    model_clear();
    #1 check_all("reset_async");
    @(posedge clk);
    #1 check_all("reset_hold");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 2'b11; rd_addr = {5'd7, 5'd0};
    c_rd_en = 3'b111; c_rd_addr = {3'd7, 3'd0, 3'd5};
    cycle("post_reset_a");
    chk("post_reset_a7", 64'(rd_data_a[15:8]), 64'h0);
    rd_addr = {5'd31, 5'd31};
    cycle("post_reset_b");
    chk("post_reset_a31", 64'(rd_data_a[7:0]), 64'h0);

    // Basic latency and hold.
    idle(); write_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h3C;
    cycle("lat_wr");
    idle(); rd_en = 2'b01; rd_addr = 10'd5;
    cycle("lat_rd");
    chk("lat_data", 64'(rd_data_a[7:0]), 64'h3C);
    chk("lat_valid", 64'(rd_valid_a[0]), 64'h1);
    idle();
    cycle("lat_hold");
    chk("hold_data", 64'(rd_data_a[7:0]), 64'h3C);
    chk("hold_valid", 64'(rd_valid_a[0]), 64'h0);

    // Collision at address 9.
    idle(); write_en = 1'b1; wr_addr = 5'd9; wr_data = 8'h11;
    cycle("col_pre");
    wr_data = 8'h22; rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    cycle("col");
    chk("col_wf1", 64'(rd_data_a[15:8]), 64'h22);
    chk("col_wf0", 64'(rd_data_b[15:8]), 64'h11);
    idle(); rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    cycle("col_after");
    chk("col_after_a", 64'(rd_data_a[15:8]), 64'h22);
    chk("col_after_b", 64'(rd_data_b[15:8]), 64'h22);

    // Dual-port independence.
    idle(); write_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h44;
    cycle("dp_w3");
    wr_addr = 5'd4; wr_data = 8'h55;
    cycle("dp_w4");
    idle(); rd_en = 2'b11; rd_addr = {5'd4, 5'd3};
    cycle("dp_r34");
    chk("dp_r34", 64'(rd_data_a), 64'h5544);
    rd_addr = {5'd4, 5'd4};
    cycle("dp_r44");
    chk("dp_r44", 64'(rd_data_a), 64'h5555);
    chk("dp_r44_valid", 64'(rd_valid_a), 64'h3);

    // Entry 0 tap, ordinary and hardwired.
    idle(); write_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h7E;
    cycle("z_wr");
    chk("z_tap_a", 64'(reg_zero_a), 64'h7E);
    chk("z_tap_b", 64'(reg_zero_b), 64'h0);
    idle(); rd_en = 2'b01; rd_addr = 10'd0;
    cycle("z_rd");
    chk("z_rd_b", 64'(rd_data_b[7:0]), 64'h0);
    write_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h99; rd_en = 2'b11; rd_addr = 10'd0;
    cycle("z_col");
    chk("z_col_b", 64'(rd_data_b), 64'h0);

    // Wide configuration: packed slices stay separate.
    idle(); c_write_en = 1'b1; c_wr_addr = 3'd7; c_wr_data = 16'hBEEF;
    cycle("sw_w7");
    c_wr_addr = 3'd1; c_wr_data = 16'h1111;
    cycle("sw_w1");
    c_wr_addr = 3'd2; c_wr_data = 16'h2222;
    cycle("sw_w2");
    idle(); c_rd_en = 3'b111; c_rd_addr = {3'd7, 3'd7, 3'd7};
    cycle("sw_r777");
    chk("sw_r777", 64'(c_rd_data), 64'hBEEF_BEEF_BEEF);
    c_rd_addr = {3'd2, 3'd1, 3'd7};
    cycle("sw_r217");
    chk("sw_r217", 64'(c_rd_data), 64'h2222_1111_BEEF);

    // Writes disabled with don't-care address/data leave storage alone.
    idle(); wr_addr = 'x; wr_data = 'x; c_wr_addr = 'x; c_wr_data = 'x;
    cycle("x_wr");
    idle(); rd_en = 2'b11; rd_addr = {5'd9, 5'd5};
    cycle("x_rd");

    // Randomized traffic with frequent same-address collisions.
    for (int n = 0; n < 400; n++) begin
      write_en = 1'($urandom); wr_addr = 5'($urandom); wr_data = 8'($urandom);
      rd_en = 2'($urandom); rd_addr = 10'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[4:0] = wr_addr;
      if ($urandom_range(0, 3) == 0) rd_addr[9:5] = wr_addr;
      c_write_en = 1'($urandom); c_wr_addr = 3'($urandom); c_wr_data = 16'($urandom);
      c_rd_en = 3'($urandom); c_rd_addr = 9'($urandom);
      if ($urandom_range(0, 2) == 0) c_rd_addr[5:3] = c_wr_addr;
      cycle("rand");
    end

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
